// File: rtl/fetch_seq_chk_pkg.sv
// Shared types for the fetch-sequence checker: the address type, the
// pipeline packet shapes it observes, and the checker's error kinds.
package fetch_seq_chk_pkg;

  localparam int PADDR_W = 32;

  typedef logic [PADDR_W-1:0] t_paddr;

  typedef struct packed {
    logic [31:0] instr;
    t_paddr      pc;
  } t_instr_pkt;

  typedef struct packed {
    logic   valid;
    t_paddr restore_pc;
  } t_br_mispred_pkt;

  typedef struct packed {
    logic   valid;
    t_paddr restore_pc;
  } t_nuke_pkt;

  typedef enum logic [1:0] {
    NONE      = 2'd0,
    BAD_PC    = 2'd1,
    NONCONTIG = 2'd2
  } t_fetch_chk_err;

  // Byte offset of n sequential instructions; wraps at the address width.
  function automatic t_paddr pc_step(input int n, input int bytes);
    return t_paddr'(n * bytes);
  endfunction

endpackage

// File: rtl/fetch_lane_cmp.sv
// Per-lane PC comparator: forms the PC this lane should carry relative to
// the group's expected base PC and flags a mismatch on a valid lane.
module fetch_lane_cmp
  import fetch_seq_chk_pkg::*;
#(
  parameter int LANE        = 0,
  parameter int INSTR_BYTES = 4
) (
  input  logic   lane_valid,
  input  t_paddr base_pc,
  input  t_paddr act_pc,
  output t_paddr lane_exp_pc,
  output logic   mismatch
);

  assign lane_exp_pc = base_pc + pc_step(LANE, INSTR_BYTES);
  assign mismatch    = lane_valid && (act_pc != lane_exp_pc);

endmodule

// File: rtl/fetch_seq_chk.sv
// Fetch sequence checker: tracks the PC the front end should deliver next
// and reports, one cycle later, groups whose lane PCs or valid mask break
// sequential flow. Observation only; nothing here feeds the pipeline.
module fetch_seq_chk
  import fetch_seq_chk_pkg::*;
#(
  parameter int FETCH_W     = 2,
  parameter int INSTR_BYTES = 4,
  parameter int ERR_CNT_W   = 8,
  localparam int LANE_W     = (FETCH_W > 1) ? $clog2(FETCH_W) : 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         decode_ready_de0,
  input  logic [FETCH_W-1:0]           valid_fe1,
  input  t_instr_pkt [FETCH_W-1:0]     instr_fe1,
  input  t_br_mispred_pkt              br_mispred_ex0,
  input  t_nuke_pkt                    nuke_rb1,
  output t_paddr                       exp_pc,
  output logic                         err_valid,
  output t_fetch_chk_err               err_kind,
  output logic [LANE_W-1:0]            err_lane,
  output t_paddr                       err_exp_pc,
  output t_paddr                       err_act_pc,
  output logic [ERR_CNT_W-1:0]         err_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_SEQ          = 2'd1,
    ST_PDG_REDIRECT = 2'd2
  } t_state;

  t_state                state_reg, state_next;
  t_paddr                exp_pc_reg, exp_pc_next;
  logic                  check_en;

  logic                  accept;
  logic                  redirect;
  t_paddr                restore_pc;
  int                    lane_count;
  logic                  contiguous;

  logic [FETCH_W-1:0]    lane_mismatch;
  t_paddr                lane_exp_pc [FETCH_W];

  logic                  chk_err;
  t_fetch_chk_err        chk_kind;
  logic [LANE_W-1:0]     chk_lane;
  t_paddr                chk_exp;
  t_paddr                chk_act;

  logic                  err_valid_reg;
  t_fetch_chk_err        err_kind_reg;
  logic [LANE_W-1:0]     err_lane_reg;
  t_paddr                err_exp_pc_reg;
  t_paddr                err_act_pc_reg;
  logic [ERR_CNT_W-1:0]  err_cnt_reg;

  assign accept     = (|valid_fe1) & decode_ready_de0 & ~reset;
  assign redirect   = nuke_rb1.valid | br_mispred_ex0.valid;
  // A nuke is older than a mispredict, so its restore PC wins.
  assign restore_pc = nuke_rb1.valid ? nuke_rb1.restore_pc : br_mispred_ex0.restore_pc;

  // Group shape: number of valid lanes and whether they form a prefix from lane 0.
  always_comb begin
    lane_count = 0;
    contiguous = 1'b1;
    for (int i = 0; i < FETCH_W; i++) begin
      if (valid_fe1[i]) lane_count = lane_count + 1;
    end
    for (int i = 1; i < FETCH_W; i++) begin
      if (valid_fe1[i] && !valid_fe1[i-1]) contiguous = 1'b0;
    end
  end

  for (genvar gi = 0; gi < FETCH_W; gi++) begin : g_lane
    fetch_lane_cmp #(
      .LANE        (gi),
      .INSTR_BYTES (INSTR_BYTES)
    ) u_cmp (
      .lane_valid  (valid_fe1[gi]),
      .base_pc     (exp_pc_reg),
      .act_pc      (instr_fe1[gi].pc),
      .lane_exp_pc (lane_exp_pc[gi]),
      .mismatch    (lane_mismatch[gi])
    );
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state_reg <= ST_IDLE;
    else       state_reg <= state_next;
  end

  // FSM next state: leave IDLE on the first accept or redirect; a redirect
  // parks us in PDG_REDIRECT until a clean accept lands on the new path.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (redirect)    state_next = ST_PDG_REDIRECT;
        else if (accept) state_next = ST_SEQ;
      end
      ST_SEQ: begin
        if (redirect) state_next = ST_PDG_REDIRECT;
      end
      ST_PDG_REDIRECT: begin
        if (accept && !redirect) state_next = ST_SEQ;
      end
      default: state_next = ST_SEQ;
    endcase
  end

  // FSM outputs: checking is only meaningful once an expected PC is known.
  always_comb begin
    check_en = 1'b1;
    case (state_reg)
      ST_IDLE: check_en = 1'b0;
      default: check_en = 1'b1;
    endcase
  end

  // Group check: a broken valid mask suppresses PC checks; otherwise the
  // lowest failing lane is reported (descending loop leaves it last-written).
  always_comb begin
    chk_err  = 1'b0;
    chk_kind = NONE;
    chk_lane = '0;
    chk_exp  = '0;
    chk_act  = '0;
    if (accept && check_en) begin
      if (!contiguous) begin
        chk_err  = 1'b1;
        chk_kind = NONCONTIG;
        chk_exp  = exp_pc_reg;
        chk_act  = instr_fe1[0].pc;
      end else begin
        for (int i = FETCH_W - 1; i >= 0; i--) begin
          if (lane_mismatch[i]) begin
            chk_err  = 1'b1;
            chk_kind = BAD_PC;
            chk_lane = LANE_W'(i);
            chk_exp  = lane_exp_pc[i];
            chk_act  = instr_fe1[i].pc;
          end
        end
      end
    end
  end

  // Expected-PC update: redirect wins; in IDLE the first group seeds the
  // sequence; a malformed group does not advance it.
  always_comb begin
    exp_pc_next = exp_pc_reg;
    if (redirect) begin
      exp_pc_next = restore_pc;
    end else if (accept) begin
      if (!check_en)
        exp_pc_next = instr_fe1[0].pc + pc_step(lane_count, INSTR_BYTES);
      else if (contiguous)
        exp_pc_next = exp_pc_reg + pc_step(lane_count, INSTR_BYTES);
    end
  end

  // Expected PC and registered error report with saturating error count.
  always_ff @(posedge clk) begin
    if (reset) begin
      exp_pc_reg     <= '0;
      err_valid_reg  <= 1'b0;
      err_kind_reg   <= NONE;
      err_lane_reg   <= '0;
      err_exp_pc_reg <= '0;
      err_act_pc_reg <= '0;
      err_cnt_reg    <= '0;
    end else begin
      exp_pc_reg     <= exp_pc_next;
      err_valid_reg  <= chk_err;
      err_kind_reg   <= chk_kind;
      err_lane_reg   <= chk_lane;
      err_exp_pc_reg <= chk_exp;
      err_act_pc_reg <= chk_act;
      if (chk_err && (err_cnt_reg != '1)) err_cnt_reg <= err_cnt_reg + 1'b1;
    end
  end

  assign exp_pc     = exp_pc_reg;
  assign err_valid  = err_valid_reg;
  assign err_kind   = err_kind_reg;
  assign err_lane   = err_lane_reg;
  assign err_exp_pc = err_exp_pc_reg;
  assign err_act_pc = err_act_pc_reg;
  assign err_cnt    = err_cnt_reg;

`ifdef SIMULATION
  // Trace every accepted lane.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int i = 0; i < FETCH_W; i++) begin
        if (valid_fe1[i]) $info("unit:FE pc:%h %s", instr_fe1[i].pc, "accepted");
      end
    end
  end
`endif

`ifdef ASSERT
  // Any reported error is a hard failure in assertion-enabled runs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!err_valid_reg)
        else $error("VASSERT fetch_seq_chk kind=%0d lane=%0d exp=%h act=%h",
                    err_kind_reg, err_lane_reg, err_exp_pc_reg, err_act_pc_reg);
    end
  end
`endif

endmodule
